// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-port integer register file with same-cycle write-to-read bypass and a
//   per-register pending-write scoreboard. Each register carries a small counter
//   of writes still outstanding, so an in-order pipeline can detect RAW hazards
//   from rbusy_o and throttle issue through issue_ready_o.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   wena_i          per write port enable            [NWP]
//   waddr_i         per write port address           [NWP*AW], port p at [p*AW +: AW]
//   wdata_i         per write port data              [NWP*XLEN]
//   rena_i          per read port enable             [NRP]
//   raddr_i         per read port address            [NRP*AW]
//   rdata_o         per read port data (combinational) [NRP*XLEN]
//   rbusy_o         read register has a write still outstanding [NRP]
//   issue_valid_i   decode issues an instruction writing issue_rd_i
//   issue_rd_i      destination register of the issued instruction
//   issue_ready_o   issue accepted this cycle
//   flush_i         clear all pending counters
//   sb_err_o        sticky: writeback to a register with nothing pending
//
// Issue handshake: an issue is taken on a rising clk edge where issue_valid_i
// and issue_ready_o are both high. issue_ready_o is a combinational function
// of the current pending state, issue_rd_i, flush_i, rst and this cycle's
// writebacks; it never depends on issue_valid_i, so decode may hold or drop
// issue_valid_i freely while ready is low.
module regfile_mp_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 2,
    parameter int CW     = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWP-1:0]      wena_i,
    input  logic [NWP*AW-1:0]   waddr_i,
    input  logic [NWP*XLEN-1:0] wdata_i,
    input  logic [NRP-1:0]      rena_i,
    input  logic [NRP*AW-1:0]   raddr_i,
    output logic [NRP*XLEN-1:0] rdata_o,
    output logic [NRP-1:0]      rbusy_o,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic                issue_ready_o,
    input  logic                flush_i,
    output logic                sb_err_o
);
    localparam int DW = $clog2(NWP + 1);
    // Wide enough to hold pend + inc and dec without wrap.
    localparam int SW = CW + DW + 1;
    localparam logic [CW-1:0] PMAX = {CW{1'b1}};

    logic [XLEN-1:0] regs [NREG];
    logic [CW-1:0]   pend [NREG];
    logic            sb_err_q;

    logic [DW-1:0]   dec      [NREG];
    logic [NREG-1:0] inc;
    logic [SW-1:0]   avail    [NREG];
    logic [CW-1:0]   pend_nxt [NREG];
    logic            err_nxt;

    // Number of write ports retiring a write to each register this cycle.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            dec[r] = '0;
            for (int p = 0; p < NWP; p++) begin
                if (wena_i[p] && (waddr_i[p*AW +: AW] == AW'(r)))
                    dec[r] = dec[r] + DW'(1);
            end
        end
    end

    // A full counter can still accept when a writeback to the same register
    // frees a slot in the same edge.
    assign issue_ready_o = !rst && !flush_i &&
                           ((issue_rd_i == '0) || (pend[issue_rd_i] != PMAX) ||
                            (dec[issue_rd_i] != '0));

    always_comb begin
        err_nxt = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = issue_valid_i && issue_ready_o && (issue_rd_i == AW'(r));
            avail[r] = SW'(pend[r]) + SW'(inc[r]);
            if (SW'(dec[r]) > avail[r]) begin
                // More writebacks than outstanding writes: clamp at zero and flag.
                pend_nxt[r] = '0;
                if (r != 0)
                    err_nxt = 1'b1;
            end else begin
                pend_nxt[r] = CW'(avail[r] - SW'(dec[r]));
            end
            if (flush_i || (r == 0))
                pend_nxt[r] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int p = 0; p < NWP; p++) begin
                if (wena_i[p] && (waddr_i[p*AW +: AW] != '0))
                    regs[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
            end
            for (int r = 0; r < NREG; r++)
                pend[r] <= pend_nxt[r];
            if (err_nxt)
                sb_err_q <= 1'b1;
        end
    end

    assign sb_err_o = sb_err_q;

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd_val;
        logic            rb_val;

        assign ra = raddr_i[i*AW +: AW];

        always_comb begin
            rd_val = '0;
            rb_val = 1'b0;
            if (!rst && rena_i[i] && (ra != '0)) begin
                rd_val = regs[ra];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWP; p++) begin
                        if (wena_i[p] && (waddr_i[p*AW +: AW] == ra))
                            rd_val = wdata_i[p*XLEN +: XLEN];
                    end
                    // A write retiring this cycle is already visible through
                    // the bypass, so it no longer makes the read busy.
                    rb_val = SW'(pend[ra]) > SW'(dec[ra]);
                end else begin
                    rb_val = pend[ra] != '0;
                end
            end
        end

        assign rdata_o[i*XLEN +: XLEN] = rd_val;
        assign rbusy_o[i]              = rb_val;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two instances (bypass on / bypass off) share all
// inputs. A reference model built from plain arrays predicts every output of
// every cycle; predictions go into a queue and a negedge monitor compares.
module tb_regfile_mp_sb;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int PMAX = 3;
    localparam int EW   = 2*2*XLEN + 2 + 2 + 1 + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        wena;
    logic [2*AW-1:0]   waddr;
    logic [2*XLEN-1:0] wdata;
    logic [1:0]        rena;
    logic [2*AW-1:0]   raddr;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic              flush;

    logic [2*XLEN-1:0] rdata1, rdata0;
    logic [1:0]        rbusy1, rbusy0;
    logic              ready1, ready0, err1, err0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(2), .NWP(2), .CW(2), .BYPASS(1)) dut_bp1 (
        .clk(clk), .rst(rst), .wena_i(wena), .waddr_i(waddr), .wdata_i(wdata),
        .rena_i(rena), .raddr_i(raddr), .rdata_o(rdata1), .rbusy_o(rbusy1),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready1),
        .flush_i(flush), .sb_err_o(err1));

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(2), .NWP(2), .CW(2), .BYPASS(0)) dut_bp0 (
        .clk(clk), .rst(rst), .wena_i(wena), .waddr_i(waddr), .wdata_i(wdata),
        .rena_i(rena), .raddr_i(raddr), .rdata_o(rdata0), .rbusy_o(rbusy0),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(ready0),
        .flush_i(flush), .sb_err_o(err0));

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_regs [NREG];
    int              m_pend [NREG];
    logic            m_err;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e_cur;
    int checks = 0;
    int fails  = 0;

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_err = 1'b0;
    endtask

    // Predict this cycle's outputs from current inputs, then advance the model.
    task automatic model_step();
        int                dec [NREG];
        logic [2*XLEN-1:0] e_rd1, e_rd0;
        logic [1:0]        e_rb1, e_rb0;
        logic              e_rdy;
        int                ra, wa, t;
        for (int r = 0; r < NREG; r++) dec[r] = 0;
        for (int p = 0; p < 2; p++)
            if (wena[p]) dec[waddr[p*AW +: AW]]++;
        e_rd1 = '0; e_rd0 = '0; e_rb1 = '0; e_rb0 = '0; e_rdy = 1'b0;
        if (rst) begin
            exp_q.push_back({e_rd1, e_rd0, e_rb1, e_rb0, e_rdy, m_err});
            model_clear();
            return;
        end
        e_rdy = !flush && (issue_rd == 0 || m_pend[issue_rd] < PMAX || dec[issue_rd] > 0);
        for (int i = 0; i < 2; i++) begin
            ra = int'(raddr[i*AW +: AW]);
            if (rena[i] && ra != 0) begin
                e_rd0[i*XLEN +: XLEN] = m_regs[ra];
                e_rd1[i*XLEN +: XLEN] = m_regs[ra];
                for (int p = 0; p < 2; p++)
                    if (wena[p] && int'(waddr[p*AW +: AW]) == ra)
                        e_rd1[i*XLEN +: XLEN] = wdata[p*XLEN +: XLEN];
                e_rb1[i] = m_pend[ra] > dec[ra];
                e_rb0[i] = m_pend[ra] != 0;
            end
        end
        exp_q.push_back({e_rd1, e_rd0, e_rb1, e_rb0, e_rdy, m_err});
        for (int r = 1; r < NREG; r++) begin
            t = m_pend[r] + ((issue_valid && e_rdy && int'(issue_rd) == r) ? 1 : 0);
            if (dec[r] > t) begin
                m_err = 1'b1;
                t = 0;
            end else begin
                t = t - dec[r];
            end
            m_pend[r] = flush ? 0 : t;
        end
        for (int p = 0; p < 2; p++) begin
            wa = int'(waddr[p*AW +: AW]);
            if (wena[p] && wa != 0) m_regs[wa] = wdata[p*XLEN +: XLEN];
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [2*XLEN-1:0] act,
                         input logic [2*XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            check("rdata_bp1", rdata1, e_cur[EW-1 -: 2*XLEN]);
            check("rdata_bp0", rdata0, e_cur[EW-1-2*XLEN -: 2*XLEN]);
            check("rbusy_bp1", {126'b0, rbusy1}, {126'b0, e_cur[5:4]});
            check("rbusy_bp0", {126'b0, rbusy0}, {126'b0, e_cur[3:2]});
            check("ready_bp1", {127'b0, ready1}, {127'b0, e_cur[1]});
            check("ready_bp0", {127'b0, ready0}, {127'b0, e_cur[1]});
            check("sb_err_bp1", {127'b0, err1}, {127'b0, e_cur[0]});
            check("sb_err_bp0", {127'b0, err0}, {127'b0, e_cur[0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst = 1'b0; wena = '0; waddr = '0; wdata = '0; rena = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        wena[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int i, input int a);
        rena[i] = 1'b1;
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        issue_valid = 1'b1;
        issue_rd = AW'(a);
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; rd(0, 5); rd(1, 5); tick();
    endtask

    initial begin
        // Unchecked power-on reset so registered outputs leave X.
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();

        // 1: reset gating of combinational outputs
        do_reset();
        idle(); rd(0, 5); rd(1, 5); tick();

        // 2: same-address writes on both ports, x0 writes dropped
        idle(); wr(0, 3, 64'hAA); wr(1, 3, 64'hBB); rd(0, 3); rd(1, 3); tick();
        idle(); rd(0, 3); rd(1, 3); tick();
        idle(); wr(0, 0, 64'h1); rd(0, 0); rd(1, 0); tick();
        idle(); rd(0, 0); tick();

        // 3: fill x7's counter, stall, then accept alongside a writeback
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); issue(7); rd(0, 7); tick();
        end
        idle(); issue(7); rd(0, 7); tick();
        idle(); issue(7); rd(0, 7); wr(1, 7, 64'h77); tick();
        idle(); rd(0, 7); issue(7); tick();

        // 4: writeback while reading with one pending
        idle(); issue(9); tick();
        idle(); rd(1, 9); wr(0, 9, 64'h55); tick();
        idle(); rd(1, 9); tick();

        // 5: writeback with nothing pending sets sticky error
        do_reset();
        idle(); wr(0, 4, 64'h44); rd(0, 4); tick();
        for (int k = 0; k < 3; k++) begin
            idle(); rd(0, 4); tick();
        end
        do_reset();
        idle(); tick();

        // 6: flush with concurrent issue and writeback, then reset mid-burst
        idle(); issue(2); tick();
        idle(); issue(2); tick();
        idle(); issue(6); tick();
        idle(); flush = 1'b1; issue(2); wr(0, 6, 64'h66); rd(0, 6); rd(1, 2); tick();
        idle(); rd(0, 6); rd(1, 2); tick();
        idle(); issue(8); tick();
        idle(); issue(8); wr(0, 8, 64'h88); rd(0, 8); tick();
        idle(); rst = 1'b1; issue(8); wr(1, 8, 64'h99); flush = 1'b1; rd(0, 8); tick();
        idle(); rd(0, 8); rd(1, 8); tick();

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 2) == 0)
                    wr(p, $urandom_range(0, 9), {$urandom, $urandom});
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 3) != 0) rd(i, $urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) issue($urandom_range(0, 9));
            tick();
        end

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
